axi_trace_stream_arbiter: RTL and testbench
===========================================

Name: axi_trace_stream_arbiter

Overview:
- Shares one 512-bit trace output stream (DMA/host path) among NUM_SRC axi4_trace_recorder instances. Each recorder emits packetised beats (valid/ready/keep/data/last).
- Packet-atomic round-robin: once a source is granted, all its beats up to and including last pass through before re-arbitration.
- Output is registered through a 2-entry skid buffer and tagged with the source index, so the host can demultiplex traces per AXI port.

Parameters:
- NUM_SRC, 4, number of recorder inputs (2..16)
- DATA_WIDTH, 512, beat width; must be a multiple of 8
- SRC_W, $clog2(NUM_SRC), width of the source tag (derived; do not override)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new grants; when low, a packet in flight still completes
- s_valid  in  NUM_SRC  per-source beat valid
- s_ready  out  NUM_SRC  per-source beat ready
- s_keep  in  NUM_SRC*DATA_WIDTH/8  per-source byte keep, source i at slice i
- s_data  in  NUM_SRC*DATA_WIDTH  per-source beat data
- s_last  in  NUM_SRC  per-source end of packet
- m_valid  out  1  output beat valid
- m_ready  in  1  output beat ready
- m_keep  out  DATA_WIDTH/8  output keep
- m_data  out  DATA_WIDTH  output data
- m_last  out  1  output end of packet
- m_src  out  SRC_W  source index of the current output beat
- busy  out  1  high when state is PKT or the skid buffer holds data
- pkt_count  out  NUM_SRC*32  per-source completed-packet counters (see Optional Feature)

Behaviour:
- Reset values (async assert, sync deassert in the caller's reset synchroniser):
  - state=IDLE, rr_ptr=0, grant=0
  - s_ready=0, m_valid=0, m_last=0, m_keep=0, m_data=0, m_src=0, busy=0, pkt_count=0
- States: IDLE, PKT.
- IDLE:
  - s_ready all 0.
  - If enable and any s_valid: pick the first set s_valid scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_SRC.
  - Latch grant at the clock edge; go to PKT.
  - Otherwise stay in IDLE.
- PKT:
  - s_ready[grant] = skid in_ready; all other s_ready = 0.
  - A beat is accepted when s_valid[grant] && s_ready[grant]; it is pushed into the skid with m_src=grant.
  - On an accepted beat with s_last=1: go to IDLE and set rr_ptr = (grant+1) mod NUM_SRC.
- Arbitration gap: exactly one idle cycle between packets on the input side. Output throughput is one beat/cycle inside a packet.
- Skid buffer (2 entries):
  - in_ready = (count<2).
  - Output is registered: first beat reaches m_valid 1 cycle after acceptance. Minimum latency s_valid→m_valid is 2 cycles from IDLE (grant + register).
  - m_* hold stable while m_valid && !m_ready.
  - Simultaneous push and pop at count=2 is not possible (in_ready=0). At count=1, push and pop in the same cycle keeps count=1.
- Boundary conditions:
  - enable dropping mid-packet: no effect until last; then the block stays in IDLE.
  - A source dropping s_valid mid-packet: grant is held and the block waits; there is no timeout.
  - Single-beat packet (s_valid with s_last in the first accepted beat): PKT lasts exactly one accepting cycle.
  - Only one source requesting: it is re-granted every other cycle; the rr_ptr advance does not starve it.
- Reset mid-packet discards the partial packet and skid contents. Recorders share the same reset.
- Payload (keep, data) is passed unmodified. No keep validation.

Optional Feature:
- Macro: TRACE_ARB_PKT_COUNT_EN.
- Defined: pkt_count[i*32 +: 32] increments by 1 when a beat with m_last=1 and m_src=i completes the output handshake (m_valid && m_ready). It wraps modulo 2^32 and is cleared only by reset.
- Not defined: pkt_count is driven constant 0 and no counter flops are instantiated.

Decomposition:
- Package trace_arb_pkg:
  - TRACE_BEAT_W=512, TRACE_KEEP_W=64
  - state enum {IDLE, PKT}
  - PKT_CNT_W=32
- Sub-module trace_skid_buffer: 2-entry registered valid/ready slice carrying {src, last, keep, data}; parameterised by payload width, with the same clk/rst_n.
- The round-robin pick is a function in the arbiter, not a separate module.

Test Plan:
- Single source: src 2 sends a 3-beat packet (data 0xA0, 0xA1, 0xA2; last on beat 3), m_ready=1 → m_src=2 on all 3 beats, m_last only on 0xA2, first m_valid 2 cycles after s_valid rises.
- Fairness: all 4 sources assert continuously, each with 2-beat packets → output order of source tags is 0,1,2,3,0,1,… with no interleaving inside a packet. With the feature enabled, pkt_count after 8 packets is 2 per source.
- Backpressure: hold m_ready=0 for 5 cycles during a 4-beat packet → m_data stable while stalled, s_ready[grant] falls after 2 buffered beats, all 4 beats delivered in order, nothing dropped or duplicated.
- enable gating: drop enable during beat 2 of a 4-beat packet from src 1 with src 3 pending → src 1 packet completes, src 3 is not granted until enable=1, then is granted first.
- Reset mid-packet: assert rst_n=0 after beat 1 of 3 → m_valid=0 and s_ready=0 immediately (async), busy=0. After release, a new packet from src 0 is granted (rr_ptr=0).
- Source stall: src 0 drops s_valid for 3 cycles mid-packet while src 1 is valid → src 1 s_ready stays 0 until src 0's last beat is accepted.

Source files
------------

// File: rtl/trace_arb_pkg.sv
// Shared constants and state type for the trace stream arbiter.
package trace_arb_pkg;

  localparam int TRACE_BEAT_W = 512;
  localparam int TRACE_KEEP_W = 64;
  localparam int PKT_CNT_W    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/trace_skid_buffer.sv
// Two-entry registered valid/ready slice. The head entry drives the output
// directly from flops. The second entry absorbs one beat when the consumer
// stalls, so the upstream ready depends only on local occupancy.
module trace_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  logic [1:0]       count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push;
  logic             pop;

  assign in_ready    = (count != 2'd2);
  assign out_valid   = (count != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_payload = head;

  // Occupancy and storage. A push with a pop is only possible at count 1,
  // where the new beat replaces the departing head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) head <= in_payload;
          else               tail <= in_payload;
        end
        2'b01: begin
          count <= count - 2'd1;
          head  <= tail;
        end
        2'b11: head <= in_payload;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_trace_stream_arbiter.sv
// Packet-atomic round-robin arbiter that merges NUM_SRC trace recorder
// streams into one output stream tagged with the source index.
// Optional feature macro: TRACE_ARB_PKT_COUNT_EN. When it is defined,
// per-source completed-packet counters are built. When it is not defined,
// pkt_count is tied to zero.
module axi_trace_stream_arbiter
  import trace_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = TRACE_BEAT_W,
  parameter int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NUM_SRC-1:0]              s_valid,
  output logic [NUM_SRC-1:0]              s_ready,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_keep,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_SRC-1:0]              s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH/8-1:0]         m_keep,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  output logic [SRC_W-1:0]                m_src,
  output logic                            busy,
  output logic [NUM_SRC*PKT_CNT_W-1:0]    pkt_count
);

  localparam int KEEP_W    = DATA_WIDTH / 8;
  localparam int PAYLOAD_W = SRC_W + 1 + KEEP_W + DATA_WIDTH;

  arb_state_t       state, state_next;
  logic [SRC_W-1:0] grant, grant_next;
  logic [SRC_W-1:0] rr_ptr, rr_ptr_next;
  logic             sel_valid;
  logic             accept;
  logic             skid_in_ready;
  logic [PAYLOAD_W-1:0] skid_in, skid_out;

  // First requester found scanning upward from ptr, wrapping at NUM_SRC.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SRC_W-1:0]   ptr);
    logic [SRC_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = SRC_W'((int'(ptr) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Successor index modulo NUM_SRC. This handles counts that are not a power of two.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    if (int'(idx) == NUM_SRC - 1) return '0;
    else                          return idx + 1'b1;
  endfunction

  assign skid_in = {grant, s_last[grant], s_keep[grant*KEEP_W +: KEEP_W],
                    s_data[grant*DATA_WIDTH +: DATA_WIDTH]};

  // Arbitration FSM. IDLE picks the next source, and PKT forwards that
  // source's beats until the beat carrying last is accepted.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    s_ready     = '0;
    sel_valid   = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (|s_valid)) begin
          grant_next = rr_pick(s_valid, rr_ptr);
          state_next = PKT;
        end
      end
      PKT: begin
        s_ready[grant] = skid_in_ready;
        sel_valid      = s_valid[grant];
        accept         = sel_valid && skid_in_ready;
        if (accept && s_last[grant]) begin
          state_next  = IDLE;
          rr_ptr_next = wrap_inc(grant);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  trace_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (sel_valid),
    .in_ready    (skid_in_ready),
    .in_payload  (skid_in),
    .out_valid   (m_valid),
    .out_ready   (m_ready),
    .out_payload (skid_out)
  );

  assign {m_src, m_last, m_keep, m_data} = skid_out;
  assign busy = (state == PKT) || m_valid;

`ifdef TRACE_ARB_PKT_COUNT_EN
  // Count packets as their final beat leaves on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (m_valid && m_ready && m_last) begin
      pkt_count[m_src*PKT_CNT_W +: PKT_CNT_W] <=
        pkt_count[m_src*PKT_CNT_W +: PKT_CNT_W] + 1'b1;
    end
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axi_trace_stream_arbiter.sv
// Directed testbench for axi_trace_stream_arbiter. Each source is fed from
// a beat queue. Output beats are captured into a queue and compared against
// hand-computed sequences.
module tb_axi_trace_stream_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int DATA_WIDTH = 512;
  localparam int KEEP_W     = DATA_WIDTH / 8;
  localparam int SRC_W      = 2;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          enable;
  logic [NUM_SRC-1:0]            s_valid;
  logic [NUM_SRC-1:0]            s_ready;
  logic [NUM_SRC*KEEP_W-1:0]     s_keep;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_data;
  logic [NUM_SRC-1:0]            s_last;
  logic                          m_valid;
  logic                          m_ready;
  logic [KEEP_W-1:0]             m_keep;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_last;
  logic [SRC_W-1:0]              m_src;
  logic                          busy;
  logic [NUM_SRC*32-1:0]         pkt_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int first_out_cyc = 0;
  int rise_cyc [NUM_SRC];

  logic [16:0]        src_q [NUM_SRC][$];
  logic [18:0]        out_q [$];
  logic [NUM_SRC-1:0] hold = '0;
  logic [NUM_SRC-1:0] hs;

  axi_trace_stream_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_keep    (s_keep),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_keep    (m_keep),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_src     (m_src),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [18:0] beat(input int src, input int last, input int data);
    return {src[1:0], last[0], data[15:0]};
  endfunction

  task automatic send_pkt(input int src, input int len, input logic [15:0] base);
    for (int k = 0; k < len; k++)
      src_q[src].push_back({(k == len - 1), base + 16'(k)});
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    out_q.delete();
  endtask

  task automatic check_out(input string tag, input logic [18:0] exp);
    logic [63:0] got;
    got = '1;
    if (out_q.size() > 0) got = 64'(out_q.pop_front());
    checkOutput(tag, got, 64'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      done = (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() == 0)
             && (s_valid == '0) && !busy;
    end
    checkOutput({tag, "_idle"}, 64'(done), 64'd1);
  endtask

  task automatic wait_handshake(input int src, input string tag);
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = s_valid[src] && s_ready[src];
    end
    checkOutput({tag, "_handshake"}, 64'(seen), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_queues();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Source drivers. Each one presents the head of its queue and pops the
  // head after a handshake observed on the preceding falling edge.
  initial begin
    s_valid = '0;
    s_last  = '0;
    s_keep  = '0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      hs = s_valid & s_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !hold[i]) begin
          if (!s_valid[i]) rise_cyc[i] = cyc;
          s_valid[i] = 1'b1;
          s_last[i]  = src_q[i][0][16];
          s_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(src_q[i][0][15:0]);
          s_keep[i*KEEP_W +: KEEP_W] = '1;
        end else begin
          s_valid[i] = 1'b0;
          s_last[i]  = 1'b0;
        end
      end
    end
  end

  // Output monitor. It captures every beat that completes the output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (out_q.size() == 0) first_out_cyc = cyc;
        out_q.push_back({m_src, m_last, m_data[15:0]});
      end
    end
  end

  // Watchdog so a wedged run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int leak;
    int unstable;

    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_ready",   64'(s_ready),   64'd0);
    checkOutput("rst_m_valid",   64'(m_valid),   64'd0);
    checkOutput("rst_m_last",    64'(m_last),    64'd0);
    checkOutput("rst_m_src",     64'(m_src),     64'd0);
    checkOutput("rst_m_data",    64'(|m_data),   64'd0);
    checkOutput("rst_m_keep",    64'(|m_keep),   64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_pkt_count", 64'(|pkt_count), 64'd0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    enable = 1'b1;

    // Single source: 3-beat packet from src 2, which has 2-cycle latency.
    @(posedge clk); #2;
    send_pkt(2, 3, 16'h00A0);
    wait_idle("t1");
    checkOutput("t1_latency", 64'(first_out_cyc - rise_cyc[2]), 64'd2);
    for (int k = 0; k < 3; k++)
      check_out($sformatf("t1_beat%0d", k), beat(2, (k == 2) ? 1 : 0, 16'hA0 + k));
    checkOutput("t1_extra", 64'(out_q.size()), 64'd0);

    // Reset mid-packet while output is stalled, then confirm that rr_ptr restarts at 0.
    @(posedge clk); #2;
    m_ready = 1'b0;
    send_pkt(2, 3, 16'h00C0);
    wait_handshake(2, "t5");
    @(posedge clk); #2;
    checkOutput("t5_pre_m_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    clear_queues();
    #1;
    checkOutput("t5_rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("t5_rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("t5_rst_busy",    64'(busy),    64'd0);
    @(posedge clk); #2;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    send_pkt(3, 1, 16'h00D0);
    send_pkt(0, 1, 16'h00D1);
    wait_idle("t5");
    check_out("t5_first",  beat(0, 1, 16'hD1));
    check_out("t5_second", beat(3, 1, 16'hD0));

    // Fairness: all sources always have 2-beat packets ready.
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) begin
      send_pkt(s, 2, 16'(s * 16));
      send_pkt(s, 2, 16'(s * 16 + 2));
    end
    wait_idle("t2");
    for (int k = 0; k < 16; k++)
      check_out($sformatf("t2_beat%0d", k),
                beat((k / 2) % 4, k % 2, ((k / 2) % 4) * 16 + (k / 8) * 2 + k % 2));
    checkOutput("t2_extra", 64'(out_q.size()), 64'd0);
`ifdef TRACE_ARB_PKT_COUNT_EN
    for (int s = 0; s < NUM_SRC; s++)
      checkOutput($sformatf("t2_pkt_count%0d", s), 64'(pkt_count[s*32 +: 32]), 64'd2);
`else
    checkOutput("t2_pkt_count_off", 64'(|pkt_count), 64'd0);
`endif

    // Backpressure: 4-beat packet from src 1 with the output stalled.
    @(posedge clk); #2;
    m_ready = 1'b0;
    send_pkt(1, 4, 16'h00B0);
    repeat (4) @(negedge clk);
    checkOutput("t3_ready_one_buffered", 64'(s_ready[1]), 64'd1);
    @(negedge clk);
    checkOutput("t3_ready_full",  64'(s_ready[1]), 64'd0);
    checkOutput("t3_head_data",   64'(m_data[15:0]), 64'h00B0);
    checkOutput("t3_busy",        64'(busy), 64'd1);
    unstable = 0;
    repeat (3) begin
      @(negedge clk);
      if (!m_valid || m_data[15:0] != 16'h00B0 || s_ready[1]) unstable++;
    end
    checkOutput("t3_stall_stable", 64'(unstable), 64'd0);
    @(posedge clk); #2;
    m_ready = 1'b1;
    wait_idle("t3");
    for (int k = 0; k < 4; k++)
      check_out($sformatf("t3_beat%0d", k), beat(1, (k == 3) ? 1 : 0, 16'hB0 + k));
    checkOutput("t3_extra", 64'(out_q.size()), 64'd0);

    // Enable gating: drop enable mid-packet from src 1 while src 3 waits.
    do_reset();
    send_pkt(1, 4, 16'h00E0);
    send_pkt(3, 1, 16'h00F0);
    wait_handshake(1, "t4");
    @(posedge clk); #2;
    enable = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("t4_src3_waiting", 64'(src_q[3].size()), 64'd1);
    checkOutput("t4_busy",         64'(busy),    64'd0);
    checkOutput("t4_s_ready",      64'(s_ready), 64'd0);
    for (int k = 0; k < 4; k++)
      check_out($sformatf("t4_beat%0d", k), beat(1, (k == 3) ? 1 : 0, 16'hE0 + k));
    checkOutput("t4_extra", 64'(out_q.size()), 64'd0);
    @(posedge clk); #2;
    enable = 1'b1;
    wait_idle("t4");
    check_out("t4_src3", beat(3, 1, 16'hF0));

    // Source stall: src 0 pauses mid-packet, and src 1 must not be served.
    @(posedge clk); #2;
    send_pkt(0, 3, 16'h0090);
    send_pkt(1, 1, 16'h0098);
    wait_handshake(0, "t6");
    @(posedge clk); #2;
    hold[0] = 1'b1;
    leak = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_ready[1]) leak++;
    end
    checkOutput("t6_grant_held", 64'(leak), 64'd0);
    checkOutput("t6_busy",       64'(busy), 64'd1);
    @(posedge clk); #2;
    hold[0] = 1'b0;
    wait_idle("t6");
    for (int k = 0; k < 3; k++)
      check_out($sformatf("t6_beat%0d", k), beat(0, (k == 2) ? 1 : 0, 16'h90 + k));
    check_out("t6_src1", beat(1, 1, 16'h98));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
